// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_scheduler
// Purpose  : Round-robin scheduler sharing one resource among NUM_REQ
//            requesters. A Moore FSM (IDLE / GRANT / SWITCH) issues a
//            registered one-hot grant. The grant rotates when the holder
//            releases its request, or when it has held the resource for
//            QUANTUM cycles while another requester waits. Every hand-over
//            passes through one all-zero SWITCH cycle so the shared
//            resource can settle.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active-low
//            en         - advance enable; 0 freezes every register
//            req        - level request per requester
//            gnt        - registered one-hot grant, all-zero when idle
//            gnt_valid  - 1 iff gnt != 0
//            gnt_id     - index of the granted requester, 0 when none
//            lock       - (RR_SCHED_LOCK_EN only) suppress quantum expiry
// Options  : `define RR_SCHED_LOCK_EN adds the lock input. When lock=1 in
//            GRANT the quantum counter holds at QUANTUM-1 instead of forcing
//            a hand-over; release is still honoured.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int QUANTUM = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int Q_W    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic                gnt_valid,
    output logic [ID_W-1:0]     gnt_id
`ifdef RR_SCHED_LOCK_EN
    ,
    input  logic                lock
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    localparam logic [Q_W-1:0]  C_Q_LAST  = Q_W'(QUANTUM - 1);
    localparam logic [ID_W-1:0] C_ID_LAST = ID_W'(NUM_REQ - 1);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt,   w_gnt_nxt;
    logic [ID_W-1:0]      r_gnt_id, w_gnt_id_nxt;
    logic [ID_W-1:0]      r_ptr,   w_ptr_nxt;
    logic [Q_W-1:0]       r_qcnt,  w_qcnt_nxt;

    logic                 w_lock;
    logic                 w_sel_found;
    logic [ID_W-1:0]      w_sel_id;
    logic [ID_W-1:0]      w_scan_id;
    int                   w_scan;
    logic [NUM_REQ-1:0]   w_sel_onehot;
    logic                 w_others;
    logic                 w_release;
    logic                 w_expire;
    logic [ID_W-1:0]      w_ptr_after;

`ifdef RR_SCHED_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Rotating priority scan: first requester at or after ptr, modulo NUM_REQ.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_scan      = 0;
        w_scan_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_scan_id = ID_W'(w_scan);
            if (!w_sel_found && req[w_scan_id]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_scan_id;
            end
        end
    end

    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_onehot[i] = (ID_W'(i) == w_sel_id);
        end
    end

    // r_gnt is the one-hot of r_gnt_id while in GRANT, so masking it out of
    // req leaves exactly the competing requesters.
    assign w_others    = |(req & ~r_gnt);
    assign w_release   = ~req[r_gnt_id];
    assign w_expire    = (r_qcnt == C_Q_LAST) && w_others && !w_lock;
    assign w_ptr_after = (r_gnt_id == C_ID_LAST) ? '0 : r_gnt_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_qcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_qcnt   <= w_qcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_qcnt_nxt   = r_qcnt;
        if (en) begin
            case (r_state)
                // SWITCH differs from IDLE only in that it lasts exactly one
                // enabled cycle; both pick the next holder the same way.
                S_IDLE, S_SWITCH: begin
                    if (w_sel_found) begin
                        w_state_nxt  = S_GRANT;
                        w_gnt_nxt    = w_sel_onehot;
                        w_gnt_id_nxt = w_sel_id;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                    end
                    w_qcnt_nxt = '0;
                end
                S_GRANT: begin
                    if (w_release || w_expire) begin
                        w_state_nxt  = S_SWITCH;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                        w_ptr_nxt    = w_ptr_after;
                        w_qcnt_nxt   = '0;
                    end else if (r_qcnt == C_Q_LAST) begin
                        // Nobody else waiting: renew the quantum without a gap.
                        // Locked with competitors waiting: park at the limit.
                        w_qcnt_nxt = w_others ? r_qcnt : '0;
                    end else begin
                        w_qcnt_nxt = r_qcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_qcnt_nxt   = '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign gnt_id    = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_scheduler
// Purpose  : Scoreboard bench for rr_grant_scheduler (NUM_REQ=4, QUANTUM=4).
//            Stimulus pushes the hand-computed grant expected in each cycle;
//            a negedge monitor pops and compares gnt, gnt_valid and gnt_id.
//            Asynchronous reset behaviour is checked directly mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler;

    localparam int NUM_REQ = 4;
    localparam int QUANTUM = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
`ifdef RR_SCHED_LOCK_EN
    logic        lock;
    initial lock = 1'b0;
`endif

    rr_grant_scheduler #(
        .NUM_REQ (NUM_REQ),
        .QUANTUM (QUANTUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
`ifdef RR_SCHED_LOCK_EN
        ,
        .lock      (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    string      test_name = "init";

    logic [3:0] m_exp;
    logic [1:0] m_exp_id;
    logic       m_exp_valid;

    // Monitor: outputs seen at the negedge belong to the current cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp       = exp_q.pop_front();
            m_exp_valid = |m_exp;
            m_exp_id    = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (m_exp[i]) m_exp_id = 2'(i);
            end
            n_checks++;
            if (gnt !== m_exp || gnt_valid !== m_exp_valid || gnt_id !== m_exp_id) begin
                n_fail++;
                $display("FAIL %s @%0t: gnt=%b valid=%b id=%0d, expected gnt=%b valid=%b id=%0d",
                         test_name, $time, gnt, gnt_valid, gnt_id, m_exp, m_exp_valid, m_exp_id);
            end
        end
    end

    // One clock cycle: apply inputs, record the grant expected in this cycle.
    task automatic cyc(input logic [3:0] r, input logic e, input logic [3:0] exp);
        req = r;
        en  = e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle and confirm outputs clear without a clock edge.
    task automatic reset_dut(input string name);
        rst = 1'b0;
        #2;
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_%s: gnt=%b valid=%b id=%0d, expected gnt=0000 valid=0 id=0",
                     name, gnt, gnt_valid, gnt_id);
        end
        req = 4'b0000;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;
        reset_dut("initial");

        // Single requester: granted next cycle, held across quantum boundaries.
        test_name = "single_req0";
        cyc(4'b0001, 1'b1, 4'b0000);
        for (int k = 0; k < 10; k++) cyc(4'b0001, 1'b1, 4'b0001);
        cyc(4'b0000, 1'b1, 4'b0001);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);

        // Full contention: 4-cycle grants separated by one gap, wrapping.
        reset_dut("before_all");
        test_name = "all_req";
        cyc(4'b1111, 1'b1, 4'b0000);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) cyc(4'b1111, 1'b1, 4'(1 << g));
            cyc(4'b1111, 1'b1, 4'b0000);
        end
        cyc(4'b1111, 1'b1, 4'b0001);
        cyc(4'b1111, 1'b1, 4'b0001);

        // Lone requester 2: continuous grant, no gap at quantum renewal.
        reset_dut("before_req2");
        test_name = "lone_req2";
        cyc(4'b0100, 1'b1, 4'b0000);
        for (int k = 0; k < 12; k++) cyc(4'b0100, 1'b1, 4'b0100);

        // Early release by requester 1, hand-over to 3 after one gap.
        reset_dut("before_release");
        test_name = "release";
        cyc(4'b1010, 1'b1, 4'b0000);
        cyc(4'b1010, 1'b1, 4'b0010);
        cyc(4'b1010, 1'b1, 4'b0010);
        cyc(4'b1000, 1'b1, 4'b0010);
        cyc(4'b1000, 1'b1, 4'b0000);
        cyc(4'b1000, 1'b1, 4'b1000);
        cyc(4'b1000, 1'b1, 4'b1000);

        // Enable freeze: in IDLE, then mid-grant delays hand-over by 3 cycles.
        reset_dut("before_enable");
        test_name = "enable_freeze";
        cyc(4'b0011, 1'b0, 4'b0000);
        cyc(4'b0011, 1'b1, 4'b0000);
        cyc(4'b0011, 1'b1, 4'b0001);
        cyc(4'b0011, 1'b1, 4'b0001);
        cyc(4'b0011, 1'b0, 4'b0001);
        cyc(4'b0011, 1'b0, 4'b0001);
        cyc(4'b0011, 1'b0, 4'b0001);
        cyc(4'b0011, 1'b1, 4'b0001);
        cyc(4'b0011, 1'b1, 4'b0001);
        cyc(4'b0011, 1'b1, 4'b0000);
        cyc(4'b0011, 1'b1, 4'b0010);

        // Reset mid-grant: grant clears at once, arbitration restarts at 0.
        reset_dut("before_midgrant");
        test_name = "reset_midgrant";
        cyc(4'b0100, 1'b1, 4'b0000);
        cyc(4'b0100, 1'b1, 4'b0100);
        cyc(4'b0100, 1'b1, 4'b0100);
        reset_dut("midgrant");
        test_name = "after_reset";
        cyc(4'b1111, 1'b1, 4'b0000);
        cyc(4'b1111, 1'b1, 4'b0001);
        cyc(4'b1111, 1'b1, 4'b0001);

        req = 4'b0000;
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
